// File: rtl/alu_wb_stage_pkg.sv
// Shared types for the ALU writeback stage: flag register layout and queued entry format.
// Widths are fixed here so the interface, FIFO and stage all agree on one entry shape.
package alu_wb_stage_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_W    = 3;
  localparam int WB_DEPTH = 2;

  // Architectural flags, MSB..LSB = Sign, Zero, Carry, Overflow.
  typedef struct packed {
    logic sign;
    logic zero;
    logic carry;
    logic ovf;
  } csr_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    csr_t              flags;
    logic [REG_W-1:0]  rd;
    logic              wr_reg;
    logic              wr_flags;
  } wb_entry_t;

endpackage

// File: rtl/alu_wb_stage_if.sv
// ALU-issue, register-file write and forwarding signals of the writeback stage.
// master = surrounding core (issues ops, grants rf port), slave = alu_wb_stage.
interface alu_wb_stage_if;
  import alu_wb_stage_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  csr_t              in_flags;
  logic [REG_W-1:0]  in_rd;
  logic              in_wr_reg;
  logic              in_wr_flags;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready;
  csr_t              csr_flags;
  csr_t              flags_view;
  logic [REG_W-1:0]  fwd_rs;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output flush, in_valid, in_result, in_flags, in_rd, in_wr_reg, in_wr_flags,
           rf_ready, fwd_rs,
    input  in_ready, rf_we, rf_waddr, rf_wdata, csr_flags, flags_view, fwd_hit, fwd_data
  );

  modport slave (
    input  flush, in_valid, in_result, in_flags, in_rd, in_wr_reg, in_wr_flags,
           rf_ready, fwd_rs,
    output in_ready, rf_we, rf_waddr, rf_wdata, csr_flags, flags_view, fwd_hit, fwd_data
  );

endinterface

// File: rtl/alu_wb_stage_fifo.sv
// DEPTH x wb_entry_t ring buffer; push lands on the edge, head visible next cycle.
// No internal backpressure: caller gates push on count != DEPTH and pop on count != 0.
module wb_fifo
  import alu_wb_stage_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  wb_entry_t     push_dat_i,
  input  logic          pop_i,
  output wb_entry_t     mem_o [DEPTH],
  output logic [PW-1:0] head_o,
  output logic [CW-1:0] count_o
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + PW'(1);
      if (pop_i)  head_d = head_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[tail_q] <= push_dat_i;
  end

  assign mem_o   = mem_q;
  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/alu_wb_stage.sv
// ALU->writeback queue: retires in order to the rf port, commits flags, serves bypass lookups.
// Min 1 cycle in_valid->rf_we; write entries stall on rf_ready, in_ready drops when full.
module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input logic           clk,
  input logic           rst,
  alu_wb_stage_if.slave wb
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t     ent [DEPTH];
  wb_entry_t     head, push_dat;
  logic [PW-1:0] head_ptr, idx;
  logic [CW-1:0] count;
  logic          has_head, push, retire;
  csr_t          csr_q, csr_d, view;
  logic          hit;
  logic [DATA_W-1:0] fdata;

  assign has_head    = (count != '0);
  assign head        = ent[head_ptr];
  assign wb.in_ready = (count != CW'(DEPTH));
  assign push        = wb.in_valid && wb.in_ready;
  // Flag-only entries never need the write port, so they leave without a grant.
  assign retire      = has_head && (!head.wr_reg || wb.rf_ready);

  assign push_dat = '{result:   wb.in_result,
                      flags:    wb.in_flags,
                      rd:       wb.in_rd,
                      wr_reg:   wb.in_wr_reg,
                      wr_flags: wb.in_wr_flags};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (wb.flush),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (retire),
    .mem_o      (ent),
    .head_o     (head_ptr),
    .count_o    (count)
  );

  assign wb.rf_we    = has_head && head.wr_reg;
  assign wb.rf_waddr = has_head ? head.rd     : '0;
  assign wb.rf_wdata = has_head ? head.result : '0;

  // A flush squashes the retiring entry's flag update but not its register write.
  always_comb begin
    csr_d = csr_q;
    if (retire && head.wr_flags && !wb.flush) csr_d = head.flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) csr_q <= '0;
    else     csr_q <= csr_d;
  end

  assign wb.csr_flags = csr_q;

  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    hit   = 1'b0;
    fdata = '0;
    view  = csr_q;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (ent[idx].wr_reg && (ent[idx].rd == wb.fwd_rs)) begin
          hit   = 1'b1;
          fdata = ent[idx].result;
        end
        if (ent[idx].wr_flags) view = ent[idx].flags;
      end
    end
  end

  assign wb.fwd_hit    = hit;
  assign wb.fwd_data   = fdata;
  assign wb.flags_view = view;

  a_no_drop: assert property (@(posedge clk) disable iff (rst) !(wb.in_valid && !wb.in_ready))
    else $error("in_valid asserted while in_ready=0: op dropped");

endmodule
